// File: rtl/xdma_stream_arbiter.sv
// rtl/xdma_stream_arbiter.sv - packet-level round-robin arbiter onto one XDMA stream with core clock gating
module xdma_stream_arbiter #(
    parameter int NUM_REQ      = 2,
    parameter int DATA_WIDTH   = 512,
    parameter int MAX_BEATS    = 64,
    parameter int RESUME_DELAY = 4
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    input  logic [NUM_REQ-1:0]            req_last,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic                          axi_tvalid,
    output logic [DATA_WIDTH-1:0]         axi_tdata,
    output logic                          axi_tlast,
    input  logic                          axi_tready,
    output logic                          core_clock_enable,
    output logic [$clog2(NUM_REQ)-1:0]    grant_id,
    output logic [31:0]                   pkt_count,
    output logic                          overrun
);

    localparam int GW = $clog2(NUM_REQ);
    localparam int BW = $clog2(MAX_BEATS);
    localparam int SW = $clog2(RESUME_DELAY + 1);
    localparam logic [BW-1:0] BEAT_MAX  = BW'(MAX_BEATS - 1);
    localparam logic [SW-1:0] STALL_SAT = SW'(RESUME_DELAY);
    localparam logic [GW-1:0] GRANT_RST = GW'(NUM_REQ - 1);
    localparam logic [GW:0]   NREQ_W    = (GW+1)'(NUM_REQ);

    typedef enum logic {IDLE, BURST} state_t;

    state_t          state, state_next;
    logic [GW-1:0]   grant_next;
    logic [GW:0]     cand;
    logic            pick_valid;
    logic [BW-1:0]   beat_cnt;
    logic [SW-1:0]   stall_cnt;
    logic            beat_at_max;
    logic            handshake;
    logic            stall;

    // Search upward from the previous grant so the last winner has lowest priority.
    always_comb begin
        pick_valid = 1'b0;
        grant_next = grant_id;
        cand       = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            cand = {1'b0, grant_id} + (GW+1)'(i);
            if (cand >= NREQ_W) begin
                cand = cand - NREQ_W;
            end
            if (!pick_valid && req_valid[cand[GW-1:0]]) begin
                pick_valid = 1'b1;
                grant_next = cand[GW-1:0];
            end
        end
    end

    // Outputs are forced quiet while reset is held, even if the state is still BURST.
    always_comb begin
        req_ready   = '0;
        axi_tvalid  = 1'b0;
        axi_tdata   = '0;
        axi_tlast   = 1'b0;
        beat_at_max = (beat_cnt == BEAT_MAX);
        if (state == BURST && !reset) begin
            axi_tvalid          = req_valid[grant_id];
            axi_tdata           = req_data[grant_id*DATA_WIDTH +: DATA_WIDTH];
            axi_tlast           = req_last[grant_id] | beat_at_max;
            req_ready[grant_id] = axi_tready;
        end
        handshake = axi_tvalid & axi_tready;
        stall     = axi_tvalid & ~axi_tready;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (pick_valid) state_next = BURST;
            BURST:   if (handshake && axi_tlast) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            grant_id  <= GRANT_RST;
            beat_cnt  <= '0;
            pkt_count <= '0;
            overrun   <= 1'b0;
        end else begin
            state <= state_next;
            if (state == IDLE) begin
                beat_cnt <= '0;
                if (pick_valid) begin
                    grant_id <= grant_next;
                end
            end else if (handshake) begin
                beat_cnt <= beat_cnt + 1'b1;
                if (axi_tlast) begin
                    pkt_count <= pkt_count + 32'd1;
                    if (beat_at_max && !req_last[grant_id]) begin
                        overrun <= 1'b1;
                    end
                end
            end
        end
    end

    // The core only restarts after RESUME_DELAY consecutive stall-free cycles.
    always_ff @(posedge clock) begin
        if (reset || stall) begin
            stall_cnt         <= '0;
            core_clock_enable <= 1'b0;
        end else begin
            if (stall_cnt != STALL_SAT) begin
                stall_cnt <= stall_cnt + 1'b1;
            end
            core_clock_enable <= (stall_cnt == STALL_SAT);
        end
    end

endmodule
